// File: rtl/range_sum_caller.sv
// Caller that launches a range generator, sums and counts its output stream, then hands back (sum, count).
// Optional build macro RANGE_SUM_CALLER_DEDUP_EN: skip values equal to the previously accepted one.
module range_sum_caller #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                    _clock,
    input  logic                    _reset,
    input  logic                    _start,
    input  logic signed [WIDTH-1:0] base,
    input  logic signed [WIDTH-1:0] limit,
    input  logic signed [WIDTH-1:0] step,
    output logic signed [WIDTH-1:0] gen_base,
    output logic signed [WIDTH-1:0] gen_limit,
    output logic signed [WIDTH-1:0] gen_step,
    output logic                    gen_start,
    output logic                    gen_ready,
    input  logic                    gen_valid,
    input  logic                    gen_done,
    input  logic signed [WIDTH-1:0] gen_0,
    input  logic                    _ready,
    output logic                    _valid,
    output logic                    _done,
    output logic signed [WIDTH-1:0] _0,
    output logic signed [WIDTH-1:0] _1
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LAUNCH  = 2'd1,
        COLLECT = 2'd2,
        EMIT    = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] base_q, base_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic [WIDTH-1:0] step_q, step_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             first_q, first_d;
    logic             gen_start_q, gen_start_d;
    logic             gen_ready_q, gen_ready_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic             xfer_c;
    logic             accept_c;
`ifdef RANGE_SUM_CALLER_DEDUP_EN
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             have_prev_q, have_prev_d;
`endif

    // State and datapath registers
    always_ff @(posedge _clock) begin
        if (_reset) begin
            state_q     <= IDLE;
            base_q      <= '0;
            limit_q     <= '0;
            step_q      <= '0;
            sum_q       <= '0;
            count_q     <= '0;
            first_q     <= 1'b0;
            gen_start_q <= 1'b0;
            gen_ready_q <= 1'b0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
`ifdef RANGE_SUM_CALLER_DEDUP_EN
            prev_q      <= '0;
            have_prev_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            limit_q     <= limit_d;
            step_q      <= step_d;
            sum_q       <= sum_d;
            count_q     <= count_d;
            first_q     <= first_d;
            gen_start_q <= gen_start_d;
            gen_ready_q <= gen_ready_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
`ifdef RANGE_SUM_CALLER_DEDUP_EN
            prev_q      <= prev_d;
            have_prev_q <= have_prev_d;
`endif
        end
    end

    // Next state; a start request restarts the call from any state
    always_comb begin
        state_d = state_q;
        if (_start) begin
            state_d = LAUNCH;
        end else begin
            case (state_q)
                LAUNCH:  state_d = COLLECT;
                COLLECT: if (gen_done && !first_q) state_d = EMIT;
                EMIT:    if (_ready) state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    // Accumulation and registered output values
    always_comb begin
        base_d   = base_q;
        limit_d  = limit_q;
        step_d   = step_q;
        sum_d    = sum_q;
        count_d  = count_q;
        xfer_c   = gen_valid && gen_ready_q;
`ifdef RANGE_SUM_CALLER_DEDUP_EN
        prev_d      = prev_q;
        have_prev_d = have_prev_q;
        accept_c    = xfer_c && !(have_prev_q && (gen_0 == prev_q));
`else
        accept_c    = xfer_c;
`endif
        if (_start) begin
            base_d  = base;
            limit_d = limit;
            step_d  = step;
            sum_d   = '0;
            count_d = '0;
`ifdef RANGE_SUM_CALLER_DEDUP_EN
            have_prev_d = 1'b0;
`endif
        end else if (accept_c) begin
            sum_d   = sum_q + gen_0;
            count_d = count_q + WIDTH'(1);
`ifdef RANGE_SUM_CALLER_DEDUP_EN
            prev_d      = gen_0;
            have_prev_d = 1'b1;
`endif
        end
        // gen_done seen in the first COLLECT cycle may be left over from the previous run
        first_d     = (state_q == LAUNCH);
        gen_start_d = (state_d == LAUNCH);
        gen_ready_d = (state_d == COLLECT);
        valid_d     = (state_d == EMIT);
        done_d      = (state_d == IDLE);
    end

    assign gen_base  = base_q;
    assign gen_limit = limit_q;
    assign gen_step  = step_q;
    assign gen_start = gen_start_q;
    assign gen_ready = gen_ready_q;
    assign _valid    = valid_q;
    assign _done     = done_q;
    assign _0        = sum_q;
    assign _1        = count_q;

endmodule

// File: tb/tb_range_sum_caller.sv
// Bench for range_sum_caller: the bench plays the callee, predicts every output cycle by cycle and
// checks against a plain-arithmetic sum/count model (dedup rule follows RANGE_SUM_CALLER_DEDUP_EN).
module tb_range_sum_caller;
    localparam int unsigned WIDTH = 32;
`ifdef RANGE_SUM_CALLER_DEDUP_EN
    localparam bit DEDUP = 1'b1;
`else
    localparam bit DEDUP = 1'b0;
`endif

    typedef logic [WIDTH-1:0] word_t;
    typedef struct {
        logic  v;
        word_t d;
        logic  dn;
    } beat_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    logic  start = 1'b0;
    word_t base = '0, limit = '0, step = '0;
    word_t gen_base, gen_limit, gen_step;
    logic  gen_start, gen_ready;
    logic  gen_valid = 1'b0, gen_done = 1'b0;
    word_t gen_0 = '0;
    logic  rdy = 1'b0;
    logic  res_valid, res_done;
    word_t res0, res1;

    // expected outputs for the current cycle
    logic  chk_en = 1'b0, chk_args = 1'b0, chk_res = 1'b0;
    logic  exp_gen_start = 1'b0, exp_gen_ready = 1'b0, exp_valid = 1'b0, exp_done = 1'b0;
    word_t exp_sum = '0, exp_cnt = '0, exp_base = '0, exp_limit = '0, exp_step = '0;
    bit    no_gaps = 1'b0;

    int tests = 0;
    int fails = 0;

    range_sum_caller #(.WIDTH(WIDTH)) dut (
        ._clock    (clk),
        ._reset    (rst),
        ._start    (start),
        .base      (base),
        .limit     (limit),
        .step      (step),
        .gen_base  (gen_base),
        .gen_limit (gen_limit),
        .gen_step  (gen_step),
        .gen_start (gen_start),
        .gen_ready (gen_ready),
        .gen_valid (gen_valid),
        .gen_done  (gen_done),
        .gen_0     (gen_0),
        ._ready    (rdy),
        ._valid    (res_valid),
        ._done     (res_done),
        ._0        (res0),
        ._1        (res1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input word_t act, input word_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Single compare process, sampling on the falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("gen_start", WIDTH'(gen_start), WIDTH'(exp_gen_start));
            chk("gen_ready", WIDTH'(gen_ready), WIDTH'(exp_gen_ready));
            chk("_valid",    WIDTH'(res_valid), WIDTH'(exp_valid));
            chk("_done",     WIDTH'(res_done),  WIDTH'(exp_done));
            if (chk_args) begin
                chk("gen_base",  gen_base,  exp_base);
                chk("gen_limit", gen_limit, exp_limit);
                chk("gen_step",  gen_step,  exp_step);
            end
            if (chk_res) begin
                chk("_0 sum",   res0, exp_sum);
                chk("_1 count", res1, exp_cnt);
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference: sum and count of a value list, wrapping, optionally dropping repeats
    function automatic void model(input word_t vals[$], output word_t s, output word_t c);
        word_t prev = '0;
        bit    have = 1'b0;
        s = '0;
        c = '0;
        foreach (vals[i]) begin
            if (!(DEDUP && have && vals[i] == prev)) begin
                s    = s + vals[i];
                c    = c + 1;
                prev = vals[i];
                have = 1'b1;
            end
        end
    endfunction

    function automatic void gen_range(input int b, input int l, input int s, output word_t q[$]);
        q.delete();
        for (int x = b; x < l; x += s) q.push_back(WIDTH'(x));
    endfunction

    // abort_mode: 0 full call, 1 stop mid-COLLECT after abort_n beats, 2 stop in EMIT without _ready
    task automatic run_call(input word_t b, input word_t l, input word_t s, input word_t vals[$],
                            input bit stale, input bit combine, input int rdy_wait,
                            input int abort_mode, input int abort_n,
                            output word_t obs_sum, output word_t obs_cnt);
        beat_t plan[$];
        beat_t bt;
        word_t m_sum, m_cnt;
        int    n;
        obs_sum = '0;
        obs_cnt = '0;
        cycle();
        start = 1'b1; base = b; limit = l; step = s;
        gen_valid = 1'b0; gen_done = 1'b0; rdy = 1'b0;
        cycle();
        start = 1'b0;
        gen_done = stale;
        exp_gen_start = 1'b1; exp_gen_ready = 1'b0; exp_valid = 1'b0; exp_done = 1'b0;
        exp_base = b; exp_limit = l; exp_step = s; chk_res = 1'b0;
        // Callee beat plan
        if (stale) begin bt.v = 1'b0; bt.d = '0; bt.dn = 1'b1; plan.push_back(bt); end
        foreach (vals[i]) begin
            if (!no_gaps) repeat ($urandom_range(0, 2)) begin
                bt.v = 1'b0; bt.d = WIDTH'($urandom); bt.dn = 1'b0; plan.push_back(bt);
            end
            bt.v = 1'b1; bt.d = vals[i]; bt.dn = 1'b0; plan.push_back(bt);
        end
        if (combine && plan.size() >= 2 && plan[plan.size()-1].v) begin
            plan[plan.size()-1].dn = 1'b1;
        end else begin
            if (plan.size() == 0 || !no_gaps) repeat ((plan.size() == 0) ? 1 : $urandom_range(0, 1)) begin
                bt.v = 1'b0; bt.d = '0; bt.dn = 1'b0; plan.push_back(bt);
            end
            bt.v = 1'b0; bt.d = '0; bt.dn = 1'b1; plan.push_back(bt);
        end
        model(vals, m_sum, m_cnt);
        n = plan.size();
        if (abort_mode == 1) n = (abort_n >= 0) ? abort_n : int'($urandom_range(0, plan.size() - 1));
        for (int k = 0; k < n; k++) begin
            cycle();
            gen_valid = plan[k].v; gen_0 = plan[k].d; gen_done = plan[k].dn;
            exp_gen_start = 1'b0; exp_gen_ready = 1'b1;
        end
        if (abort_mode == 1) begin
            @(negedge clk);
            #1;
            exp_gen_start = 1'b0; exp_gen_ready = 1'b1;
            return;
        end
        for (int w = 0; w <= rdy_wait; w++) begin
            cycle();
            gen_valid = 1'b0; gen_done = 1'b0;
            rdy = (w == rdy_wait) && (abort_mode != 2);
            exp_gen_start = 1'b0; exp_gen_ready = 1'b0; exp_valid = 1'b1; exp_done = 1'b0;
            exp_sum = m_sum; exp_cnt = m_cnt; chk_res = 1'b1;
            obs_sum = res0; obs_cnt = res1;
        end
        if (abort_mode == 2) return;
        cycle();
        rdy = 1'b0;
        exp_valid = 1'b0; exp_done = 1'b1; chk_res = 1'b0;
    endtask

    initial begin
        word_t q[$];
        word_t os, oc;
        int    mode;
        int    last_mode;
        // Reset
        cycle();
        cycle();
        exp_gen_start = 1'b0; exp_gen_ready = 1'b0; exp_valid = 1'b0; exp_done = 1'b0;
        exp_base = '0; exp_limit = '0; exp_step = '0; exp_sum = '0; exp_cnt = '0;
        chk_args = 1'b1; chk_res = 1'b1; chk_en = 1'b1;
        rst = 1'b0;
        cycle();
        exp_done = 1'b1; chk_res = 1'b0;

        // Stream 0,0,2,2,...,8,8 released immediately
        q.delete();
        for (int i = 0; i < 10; i++) q.push_back(WIDTH'((i / 2) * 2));
        run_call(WIDTH'(0), WIDTH'(10), WIDTH'(1), q, 1'b0, 1'b0, 0, 0, -1, os, oc);
        chk("lit stream sum",   os, DEDUP ? WIDTH'(20) : WIDTH'(40));
        chk("lit stream count", oc, DEDUP ? WIDTH'(5)  : WIDTH'(10));

        // Same stream with _ready held low 3 cycles
        run_call(WIDTH'(0), WIDTH'(10), WIDTH'(1), q, 1'b1, 1'b0, 3, 0, -1, os, oc);
        chk("lit hold sum",   os, DEDUP ? WIDTH'(20) : WIDTH'(40));
        chk("lit hold count", oc, DEDUP ? WIDTH'(5)  : WIDTH'(10));

        // Empty range 0,0,1
        gen_range(0, 0, 1, q);
        run_call(WIDTH'(0), WIDTH'(0), WIDTH'(1), q, 1'b0, 1'b0, 0, 0, -1, os, oc);
        chk("lit empty sum",   os, WIDTH'(0));
        chk("lit empty count", oc, WIDTH'(0));

        // Last value 7 arrives together with gen_done
        no_gaps = 1'b1;
        q.delete(); q.push_back(WIDTH'(3)); q.push_back(WIDTH'(7));
        run_call(WIDTH'(3), WIDTH'(8), WIDTH'(4), q, 1'b0, 1'b1, 1, 0, -1, os, oc);
        chk("lit combined sum",   os, WIDTH'(10));
        chk("lit combined count", oc, WIDTH'(2));

        // Reset after 3 transfers, with a value offered on the reset edge
        q.delete();
        for (int i = 1; i <= 4; i++) q.push_back(WIDTH'(i));
        run_call(WIDTH'(1), WIDTH'(5), WIDTH'(1), q, 1'b0, 1'b0, 0, 1, 3, os, oc);
        cycle();
        rst = 1'b1; gen_valid = 1'b1; gen_0 = WIDTH'(5);
        cycle();
        rst = 1'b0;
        exp_gen_start = 1'b0; exp_gen_ready = 1'b0; exp_valid = 1'b0; exp_done = 1'b0;
        exp_base = '0; exp_limit = '0; exp_step = '0; exp_sum = '0; exp_cnt = '0; chk_res = 1'b1;
        cycle();
        gen_valid = 1'b0;
        exp_done = 1'b1;
        cycle();
        chk_res = 1'b0;
        no_gaps = 1'b0;
        gen_range(2, 12, 3, q);
        run_call(WIDTH'(2), WIDTH'(12), WIDTH'(3), q, 1'b0, 1'b0, 0, 0, -1, os, oc);
        chk("lit post-reset sum",   os, WIDTH'(26));
        chk("lit post-reset count", oc, WIDTH'(4));

        // Reset coinciding with start stays idle
        cycle();
        rst = 1'b1; start = 1'b1;
        cycle();
        rst = 1'b0; start = 1'b0;
        exp_done = 1'b0; exp_base = '0; exp_limit = '0; exp_step = '0;
        cycle();
        exp_done = 1'b1;
        cycle();

        // Randomized calls, including aborts in COLLECT and EMIT
        last_mode = 0;
        for (int t = 0; t < 40; t++) begin
            int kind;
            int b, s, l;
            kind = int'($urandom_range(0, 2));
            b = int'($urandom_range(0, 20));
            s = int'($urandom_range(1, 4));
            l = b + int'($urandom_range(0, 30));
            if (kind == 0) begin
                gen_range(b, l, s, q);
            end else begin
                q.delete();
                repeat ($urandom_range(0, 8))
                    q.push_back((kind == 1) ? WIDTH'($urandom_range(0, 2)) : WIDTH'($urandom));
            end
            mode = int'($urandom_range(0, 9));
            mode = (mode >= 9) ? 2 : (mode >= 7) ? 1 : 0;
            run_call(WIDTH'(b), WIDTH'(l), WIDTH'(s), q, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), mode, -1, os, oc);
            last_mode = mode;
        end
        if (last_mode != 0) begin
            gen_range(5, 9, 1, q);
            run_call(WIDTH'(5), WIDTH'(9), WIDTH'(1), q, 1'b0, 1'b0, 0, 0, -1, os, oc);
        end
        cycle();
        cycle();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/range_sum_caller.md
RANGE_SUM_CALLER -- requirements
Module: range_sum_caller

Interface
REQ-001 Parameter WIDTH, default 32: width of all data, argument and accumulator signals (signed).
REQ-002 Clock: _clock  in  1  single clock; all state updates on the rising edge.
REQ-003 Reset: _reset  in  1  synchronous, active-high.
REQ-004 Start: _start  in  1  captures base/limit/step and begins a call.
REQ-005 Call arguments: base, limit, step  in  WIDTH each  arguments forwarded to the callee generator.
REQ-006 Callee arguments: gen_base, gen_limit, gen_step  out  WIDTH each  registered copies of the captured arguments.
REQ-007 Callee start: gen_start  out  1  one-cycle start pulse to the callee.
REQ-008 Callee handshake: gen_ready  out  1  consumer side of the callee ready/valid handshake.
REQ-009 Callee data: gen_valid  in  1; gen_done  in  1; gen_0  in  WIDTH  callee output value.
REQ-010 Result handshake: _ready  in  1; _valid  out  1; _done  out  1  producer side of the result handshake.
REQ-011 Result values: _0  out  WIDTH  sum; _1  out  WIDTH  count of accepted values.

Function
REQ-012 FSM states SHALL be IDLE, LAUNCH, COLLECT and EMIT.
REQ-013 IDLE: _done=1 every cycle; _valid=0; gen_start=0; gen_ready=0.
REQ-014 _start=1 in any state: capture the arguments into gen_base/gen_limit/gen_step, clear sum, count and prev-flag, go to LAUNCH next cycle, _done=0.
REQ-015 LAUNCH: drive gen_start=1 for exactly one cycle, then COLLECT.
REQ-016 COLLECT: drive gen_ready=1; ignore gen_done in the first COLLECT cycle (stale callee state).
REQ-017 Transfer = gen_valid && gen_ready on the clock edge: sum += gen_0 and count += 1, both wrapping modulo 2^WIDTH.
REQ-018 gen_done=1 in COLLECT (after the first cycle): deassert gen_ready next cycle and go to EMIT.
REQ-019 gen_valid=1 and gen_done=1 in the same cycle: the value is accepted before moving to EMIT.
REQ-020 EMIT: _valid=1 with _0=sum and _1=count, held stable until a cycle with _ready=1.
REQ-021 EMIT with _ready=1: the next cycle has _valid=0, state IDLE and _done=1.
REQ-022 Latency, start to first gen_start: 1 cycle; gen_done to _valid: 1 cycle.
REQ-023 Empty callee sequence (gen_done with no transfers): emit sum=0, count=0.
REQ-024 _start during LAUNCH, COLLECT or EMIT: abort the current call (any pending result is discarded) and restart per REQ-014.

Reset
REQ-025 _reset=1: next cycle state=IDLE, _valid=0, _done=0, _0=0, _1=0, gen_start=0, gen_ready=0, gen_base/limit/step=0.
REQ-026 _reset takes precedence over a simultaneous _start.
REQ-027 Reset mid-COLLECT: gen_ready drops the following cycle; no further transfers are accepted.

Configuration
REQ-028 Macro RANGE_SUM_CALLER_DEDUP_EN defined: a transferred value equal to the last accepted value is handshaken but not added to sum or count; the first value after start is always accepted.
REQ-029 Macro RANGE_SUM_CALLER_DEDUP_EN undefined: every transfer is accumulated; the prev register and comparator are absent.

Verification
REQ-030 Callee emits 0,0,2,2,4,4,6,6,8,8 then done, DEDUP off -> _0=40, _1=10, _valid for one cycle with _ready=1.
REQ-031 Same stream with RANGE_SUM_CALLER_DEDUP_EN -> _0=20, _1=5.
REQ-032 Callee done with no values (range 0,0,1) -> _0=0, _1=0, _valid=1, then _done=1.
REQ-033 _ready held low 3 cycles in EMIT with sum 40 -> _valid, _0=40 and _1=10 stable all 3 cycles; release on the 4th cycle.
REQ-034 Callee gen_valid=1 with gen_0=7 and gen_done=1 in the same cycle -> the result includes 7.
REQ-035 _reset after 3 transfers in COLLECT -> gen_ready=0 and _valid=0 next cycle; then IDLE with _done=1; a new _start runs a clean call.
